seg7_to_estado: RTL and testbench

SEG7_TO_ESTADO -- requirements
Module: seg7_to_estado

---
 rtl/seg7_to_estado.sv | 139 +++++++++++++
 tb/tb_seg7_to_estado.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_to_estado.sv
// Seven-segment pattern decoder: synchronizes and debounces seg_in, then maps letter patterns to a 3-bit state code.
// Optional saturating error counter on err_cnt when SEG7DEC_ERRCNT_EN is defined.
module seg7_to_estado #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [2:0] estado,
    output logic       estado_valid,
    output logic       estado_chg,
    output logic       blank,
    output logic       err
`ifdef SEG7DEC_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned CNT_W = 4;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [SEG_W-1:0] s1, s2;
    logic [SEG_W-1:0] cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       estado_n;
    logic             valid_n, blank_n, chg_n, err_n;
    logic [2:0]       dec_code;
    logic             dec_known, dec_blank;

    // Two-flop synchronizer; all-off is the idle display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= SEG_OFF;
            s2 <= SEG_OFF;
        end else begin
            s1 <= seg_in;
            s2 <= s1;
        end
    end

    // Letter table for the candidate pattern
    always_comb begin
        dec_code  = 3'd0;
        dec_known = 1'b1;
        dec_blank = 1'b0;
        case (cand)
            7'b1100010: dec_code = 3'd0;
            7'b0001000: dec_code = 3'd1;
            7'b0000111: dec_code = 3'd2;
            7'b0110000: dec_code = 3'd3;
            7'b1000001: dec_code = 3'd4;
            SEG_OFF: begin
                dec_known = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_known = 1'b0;
        endcase
    end

    // Next state: any change restarts settling; commit once stable long enough
    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        estado_n = estado;
        valid_n  = estado_valid;
        blank_n  = blank;
        chg_n    = 1'b0;
        err_n    = 1'b0;
        if (s2 != cand) begin
            cand_n  = s2;
            cnt_n   = '0;
            state_n = ST_SETTLE;
        end else if (state == ST_SETTLE) begin
            if (cnt < CNT_LAST) begin
                cnt_n = cnt + CNT_W'(1);
            end else if (dec_known) begin
                state_n  = ST_LOCKED;
                chg_n    = !estado_valid || (dec_code != estado);
                estado_n = dec_code;
                valid_n  = 1'b1;
                blank_n  = 1'b0;
            end else if (dec_blank) begin
                state_n = ST_LOCKED;
                valid_n = 1'b0;
                blank_n = 1'b1;
            end else begin
                state_n = ST_FAULT;
                valid_n = 1'b0;
                blank_n = 1'b0;
                err_n   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_SETTLE;
            cand         <= SEG_OFF;
            cnt          <= '0;
            estado       <= 3'b000;
            estado_valid <= 1'b0;
            blank        <= 1'b0;
            estado_chg   <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            cand         <= cand_n;
            cnt          <= cnt_n;
            estado       <= estado_n;
            estado_valid <= valid_n;
            blank        <= blank_n;
            estado_chg   <= chg_n;
            err          <= err_n;
        end
    end

`ifdef SEG7DEC_ERRCNT_EN
    // Updates on the same edge that raises err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (err_n && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_to_estado.sv
// Scoreboard bench for seg7_to_estado: a segment-level model predicts pulses and levels from hold lengths.
module tb_seg7_to_estado;

    localparam int S = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [2:0] estado;
    logic       estado_valid, estado_chg, blank, err;
`ifdef SEG7DEC_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    seg7_to_estado #(.STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_in       (seg_in),
        .estado       (estado),
        .estado_valid (estado_valid),
        .estado_chg   (estado_chg),
        .blank        (blank),
        .err          (err)
`ifdef SEG7DEC_ERRCNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    typedef struct {
        int       cycle;
        bit       is_err;
        bit [2:0] estado;
    } ev_t;

    ev_t      evq[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    logic [6:0] letters [5] = '{7'b1100010, 7'b0001000, 7'b0000111, 7'b0110000, 7'b1000001};
    logic [6:0] prev_pat;

    // Model state: what a display reader would believe after each accepted pattern
    bit [2:0] m_estado;
    bit       m_valid, m_blank;
    int       m_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -1 unknown, -2 blank, else letter code
    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 5; i++) if (letters[i] == p) return i;
        if (p == 7'b1111111) return -2;
        return -1;
    endfunction

    task automatic model_accept(input logic [6:0] p, input int at_cycle);
        int c;
        ev_t e;
        c = decode(p);
        if (c >= 0) begin
            if (!m_valid || (m_estado != 3'(c))) begin
                e.cycle = at_cycle; e.is_err = 0; e.estado = 3'(c);
                evq.push_back(e);
            end
            m_estado = 3'(c); m_valid = 1; m_blank = 0;
        end else if (c == -2) begin
            m_valid = 0; m_blank = 1;
        end else begin
            e.cycle = at_cycle; e.is_err = 1; e.estado = m_estado;
            evq.push_back(e);
            m_valid = 0; m_blank = 0;
            if (m_err < 255) m_err++;
        end
    endtask

    task automatic model_reset();
        m_estado = 0; m_valid = 0; m_blank = 0; m_err = 0;
    endtask

    task automatic check_levels(input string tag);
        check({tag, "_estado"}, int'(estado), int'(m_estado));
        check({tag, "_valid"}, int'(estado_valid), int'(m_valid));
        check({tag, "_blank"}, int'(blank), int'(m_blank));
`ifdef SEG7DEC_ERRCNT_EN
        check({tag, "_err_cnt"}, int'(err_cnt), m_err);
`endif
    endtask

    // Present p for k sampling edges; accepted iff held for at least S+1 samples
    task automatic apply_seg(input logic [6:0] p, input int k, input bit lvl, input string tag);
        int start;
        seg_in = p;
        prev_pat = p;
        start = cyc + 1;
        if (k >= S + 1) model_accept(p, start + S + 2);
        repeat (k) @(negedge clk);
        if (lvl) check_levels(tag);
    endtask

    function automatic logic [6:0] rand_unknown(input logic [6:0] avoid);
        logic [6:0] p;
        do p = 7'($urandom); while (decode(p) != -1 || p == avoid);
        return p;
    endfunction

    function automatic logic [6:0] rand_pat(input logic [6:0] avoid);
        logic [6:0] p;
        int r;
        do begin
            r = $urandom_range(0, 6);
            if (r < 5) p = letters[r];
            else if (r == 5) p = 7'b1111111;
            else p = rand_unknown(avoid);
        end while (p == avoid);
        return p;
    endfunction

    // Monitor: every pulse must match the head of the scoreboard
    bit prev_pulse = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (estado_chg || err) begin
                check("pulse_exclusive", int'(estado_chg && err), 0);
                check("pulse_not_back_to_back", int'(prev_pulse), 0);
                if (evq.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    check("evt_cycle", cyc, e.cycle);
                    check("evt_is_err", int'(err), int'(e.is_err));
                    check("evt_estado", int'(estado), int'(e.estado));
                    check("evt_valid", int'(estado_valid), e.is_err ? 0 : 1);
                    check("evt_blank", int'(blank), 0);
                end
            end else if (evq.size() != 0 && evq[0].cycle < cyc) begin
                ev_t e;
                e = evq.pop_front();
                check("missing_pulse_at_cycle", cyc, e.cycle);
            end
            prev_pulse = estado_chg || err;
        end else begin
            prev_pulse = 0;
        end
    end

    initial begin
        int k, t, waitc;
        logic [6:0] p;
        rst_n = 1'b0;
        seg_in = 7'b1111111;
        prev_pat = 7'b1111111;
        model_reset();
        repeat (3) @(negedge clk);
        check_levels("reset");
        check("reset_chg", int'(estado_chg), 0);
        check("reset_err", int'(err), 0);
        rst_n = 1'b1;
        apply_seg(7'b1111111, 10, 1, "post_reset_blank");

        apply_seg(7'b0001000, S + 6, 1, "letter_001");
        apply_seg(7'b0110000, S + 6, 1, "letter_011");
        apply_seg(7'b1000001, 3, 0, "glitch");
        apply_seg(7'b0110000, S + 6, 1, "after_glitch");
        apply_seg(7'b1010101, S + 6, 1, "unknown_err");
        apply_seg(7'b0110000, S, 0, "short_S");
        apply_seg(7'b0000111, S + 1, 0, "exact_S1");
        apply_seg(7'b1111111, S + 6, 1, "blank_after_S1");
        apply_seg(7'b0000111, S + 6, 1, "same_code_after_blank");

        for (int i = 0; i < 80; i++) begin
            p = rand_pat(prev_pat);
            t = $urandom_range(0, 9);
            if (t < 3) k = $urandom_range(1, S);
            else if (t == 3) k = S + 1;
            else k = $urandom_range(S + 3, S + 8);
            apply_seg(p, k, (k >= S + 3), "rand");
        end

        for (int i = 0; i < 300; i++) begin
            apply_seg(rand_unknown(prev_pat), S + 3, 0, "sat_unknown");
            apply_seg(7'b1111111, S + 3, (i % 50 == 49), "sat_blank");
        end
        check("sat_model_count", m_err, 255);

        apply_seg(7'b0001000, S + 6, 1, "pre_reset_lock");
        apply_seg(7'b1000001, 3, 0, "mid_settle");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_levels("mid_reset");
        check("mid_reset_chg", int'(estado_chg), 0);
        check("mid_reset_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply_seg(7'b1000001, 10, 1, "after_mid_reset");

        waitc = 0;
        while (evq.size() != 0 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("scoreboard_drained", evq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
